// File: rtl/bin_to_seg_scan.sv
// Binary to multiplexed common-anode 7-segment driver.
// Sequential double-dabble conversion feeding a committed display register and a digit scanner.
//
// state  | meaning
// IDLE   | ready for a new value, outReady high
// SHIFT  | one double-dabble step per clock, BIN_W steps
// COMMIT | publish BCD result and overflow flag, pulse outDone
module bin_to_seg_scan #(
  parameter int BIN_W      = 14,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV_W = 18
) (
  input  logic              inClk,
  input  logic              inRstN,
  input  logic [BIN_W-1:0]  inBin,
  input  logic              inValid,
  output logic              outReady,
  output logic              outDone,
  input  logic              inBlankEn,
  input  logic [DIGITS-1:0] inDp,
  output logic [7:0]        outDisp,
  output logic [DIGITS-1:0] outDispEn
);

  localparam int WORK_W = 4 * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W  = 5;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  localparam logic [31:0] OVF_LIMIT = pow10(DIGITS);

  function automatic logic [7:0] segOf(input logic [3:0] nib);
    case (nib)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} stateT;

  stateT                    state;
  logic [BIN_W-1:0]         shiftReg;
  logic [WORK_W-1:0]        work;
  logic [WORK_W-1:0]        workAdj;
  logic [WORK_W-1:0]        dispReg;
  logic [WORK_W+BIN_W-1:0]  shifted;
  logic                     ovfPend;
  logic                     ovfFlag;
  logic [CNT_W-1:0]         bitCnt;
  logic [SCAN_DIV_W-1:0]    prescale;
  logic [IDX_W-1:0]         digitIdx;
  logic [DIGITS-1:0]        zeroFrom;
  logic                     allZero;
  logic [3:0]               curNib;
  logic                     curZero;
  logic                     curDp;
  logic [7:0]               segNext;
  logic [DIGITS-1:0]        enNext;

  always_comb begin
    workAdj = work;
    for (int k = 0; k < DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5) workAdj[4*k +: 4] = work[4*k +: 4] + 4'd3;
    end
    shifted = {workAdj, shiftReg} << 1;
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state    <= IDLE;
      shiftReg <= '0;
      work     <= '0;
      dispReg  <= '0;
      ovfPend  <= 1'b0;
      ovfFlag  <= 1'b0;
      bitCnt   <= '0;
      outReady <= 1'b1;
      outDone  <= 1'b0;
    end else begin
      outDone <= 1'b0;
      case (state)
        IDLE: begin
          if (inValid) begin
            shiftReg <= inBin;
            work     <= '0;
            ovfPend  <= (32'(inBin) >= OVF_LIMIT);
            bitCnt   <= CNT_W'(BIN_W);
            outReady <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          work     <= shifted[WORK_W+BIN_W-1 -: WORK_W];
          shiftReg <= shifted[BIN_W-1:0];
          bitCnt   <= bitCnt - 1'b1;
          if (bitCnt == CNT_W'(1)) state <= COMMIT;
        end
        COMMIT: begin
          dispReg  <= work;
          ovfFlag  <= ovfPend;
          outDone  <= 1'b1;
          outReady <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // zeroFrom[k]: nibbles k..DIGITS-1 are all zero, i.e. digit k is a leading zero
  always_comb begin
    allZero  = 1'b1;
    zeroFrom = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      allZero     = allZero & (dispReg[4*k +: 4] == 4'd0);
      zeroFrom[k] = allZero;
    end
    curNib  = 4'd0;
    curZero = 1'b0;
    curDp   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digitIdx == IDX_W'(k)) begin
        curNib  = dispReg[4*k +: 4];
        curZero = (k != 0) && zeroFrom[k];
        curDp   = inDp[k];
      end
    end
    if (ovfFlag)                    segNext = 8'hBF;
    else if (inBlankEn && curZero)  segNext = 8'hFF;
    else                            segNext = segOf(curNib);
    if (curDp) segNext[7] = 1'b0;
    enNext = ~(DIGITS'(1) << digitIdx);
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      prescale  <= '0;
      digitIdx  <= '0;
      outDisp   <= 8'hFF;
      outDispEn <= '1;
    end else begin
      prescale <= prescale + 1'b1;
      if (&prescale) begin
        digitIdx <= (digitIdx == IDX_W'(DIGITS - 1)) ? '0 : digitIdx + 1'b1;
      end
      outDisp   <= segNext;
      outDispEn <= enNext;
    end
  end

endmodule

// File: tb/tb_bin_to_seg_scan.sv
// Scoreboard bench for bin_to_seg_scan: a 4-digit and a 6-digit instance with a fast scan.
module tb_bin_to_seg_scan;

  typedef struct {
    bit         sel;
    logic [7:0] en;
    logic [7:0] seg;
    string      name;
  } slotT;

  logic        inClk;
  logic        rstN;
  logic [13:0] bin4;
  logic        valid4, ready4, done4;
  logic        blank;
  logic [3:0]  dp4;
  logic [7:0]  disp4;
  logic [3:0]  en4;
  logic [19:0] bin6;
  logic        valid6, ready6, done6;
  logic [5:0]  dp6;
  logic [7:0]  disp6;
  logic [5:0]  en6;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   monBusy = 0;
  slotT slotQ[$];
  int   doneQ4[$];
  int   doneQ6[$];

  bin_to_seg_scan #(.BIN_W(14), .DIGITS(4), .SCAN_DIV_W(2)) dut4 (
    .inClk(inClk), .inRstN(rstN), .inBin(bin4), .inValid(valid4), .outReady(ready4),
    .outDone(done4), .inBlankEn(blank), .inDp(dp4), .outDisp(disp4), .outDispEn(en4));

  bin_to_seg_scan #(.BIN_W(20), .DIGITS(6), .SCAN_DIV_W(2)) dut6 (
    .inClk(inClk), .inRstN(rstN), .inBin(bin6), .inValid(valid6), .outReady(ready6),
    .outDone(done6), .inBlankEn(blank), .inDp(dp6), .outDisp(disp6), .outDispEn(en6));

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;
  always @(posedge inClk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // slot monitor: pop expectation, wait for its digit enable, compare segments
  initial begin
    slotT e;
    int   n;
    forever begin
      @(negedge inClk);
      if (slotQ.size() > 0) begin
        monBusy = 1;
        e = slotQ.pop_front();
        n = 0;
        while ((e.sel ? {2'b0, en6} : {4'b0, en4}) != e.en && n < 64) begin
          @(negedge inClk);
          n++;
        end
        checks++;
        if ((e.sel ? {2'b0, en6} : {4'b0, en4}) != e.en) begin
          errors++;
          $display("FAIL %s: enable %h never appeared", e.name, e.en);
        end else if ((e.sel ? disp6 : disp4) !== e.seg) begin
          errors++;
          $display("FAIL %s: en %h disp got %h, expected %h", e.name, e.en,
                   e.sel ? disp6 : disp4, e.seg);
        end
        monBusy = 0;
      end
    end
  end

  always @(negedge inClk) begin
    if (rstN && done4) begin
      checks++;
      if (doneQ4.size() == 0) begin
        errors++;
        $display("FAIL done4_unexpected: pulse at cycle %0d, expected none", cyc);
      end else begin
        int e4;
        e4 = doneQ4.pop_front();
        if (cyc != e4) begin
          errors++;
          $display("FAIL done4_latency: pulse at cycle %0d, expected %0d", cyc, e4);
        end
      end
    end
    if (rstN && done6) begin
      checks++;
      if (doneQ6.size() == 0) begin
        errors++;
        $display("FAIL done6_unexpected: pulse at cycle %0d, expected none", cyc);
      end else begin
        int e6;
        e6 = doneQ6.pop_front();
        if (cyc != e6) begin
          errors++;
          $display("FAIL done6_latency: pulse at cycle %0d, expected %0d", cyc, e6);
        end
      end
    end
  end

  task automatic pushSlot(input bit sel, input logic [7:0] en, input logic [7:0] seg, input string nm);
    slotT s;
    s.sel = sel; s.en = en; s.seg = seg; s.name = nm;
    slotQ.push_back(s);
  endtask

  task automatic drain();
    int n = 0;
    while ((slotQ.size() > 0 || monBusy) && n < 600) begin
      @(negedge inClk);
      n++;
    end
    if (slotQ.size() > 0 || monBusy) chk("drain_timeout", 1, 0);
  endtask

  task automatic pushSlots4(input logic [7:0] s3, input logic [7:0] s2, input logic [7:0] s1,
                            input logic [7:0] s0, input string tag);
    pushSlot(0, 8'h0E, s0, {tag, "_d0"});
    pushSlot(0, 8'h0D, s1, {tag, "_d1"});
    pushSlot(0, 8'h0B, s2, {tag, "_d2"});
    pushSlot(0, 8'h07, s3, {tag, "_d3"});
    drain();
  endtask

  task automatic settle();
    repeat (3) @(negedge inClk);
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic accept4(input logic [13:0] v);
    int n = 0;
    while (!ready4 && n < 100) begin
      @(negedge inClk);
      n++;
    end
    if (!ready4) chk("accept4_timeout", 0, 1);
    bin4 = v;
    valid4 = 1'b1;
    @(posedge inClk);
    @(negedge inClk);
    valid4 = 1'b0;
    bin4 = 14'h3FFF;
    doneQ4.push_back(cyc + 15);
  endtask

  task automatic waitIdle4(input int expLow);
    int n = 0;
    while (!ready4 && n < 60) begin
      @(negedge inClk);
      n++;
    end
    if (expLow >= 0) chk("ready_low_cycles", n, expLow);
    else if (!ready4) chk("idle4_timeout", 0, 1);
  endtask

  initial begin
    int n;
    logic [5:0] prev;
    logic [5:0] expEn;
    rstN = 1'b0;
    valid4 = 1'b0; bin4 = '0; blank = 1'b0; dp4 = '0;
    valid6 = 1'b0; bin6 = '0; dp6 = '0;
    repeat (2) @(negedge inClk);
    chk("rst_disp4", disp4, 8'hFF);
    chk("rst_en4", en4, 4'hF);
    chk("rst_ready4", ready4, 1);
    chk("rst_done4", done4, 0);
    chk("rst_en6", en6, 6'h3F);
    rstN = 1'b1;
    settle();
    pushSlots4(8'hC0, 8'hC0, 8'hC0, 8'hC0, "init_zero");

    accept4(14'd1234); waitIdle4(15); settle();
    pushSlots4(8'hF9, 8'hA4, 8'hB0, 8'h99, "v1234");

    accept4(14'd9999); waitIdle4(15); settle();
    pushSlots4(8'h90, 8'h90, 8'h90, 8'h90, "v9999");

    // reset with a conversion in flight
    accept4(14'd1234);
    repeat (5) @(negedge inClk);
    doneQ4.delete();
    rstN = 1'b0;
    #1;
    chk("midrst_disp4", disp4, 8'hFF);
    chk("midrst_en4", en4, 4'hF);
    chk("midrst_ready4", ready4, 1);
    @(negedge inClk);
    chk("midrst_done4", done4, 0);
    rstN = 1'b1;
    settle();
    pushSlots4(8'hC0, 8'hC0, 8'hC0, 8'hC0, "after_rst");

    accept4(14'd10000); waitIdle4(15); settle();
    pushSlots4(8'hBF, 8'hBF, 8'hBF, 8'hBF, "ovf");
    blank = 1'b1; settle();
    pushSlot(0, 8'h07, 8'hBF, "ovf_blank_d3"); drain();
    blank = 1'b0;

    accept4(14'd0); waitIdle4(15); settle();
    pushSlots4(8'hC0, 8'hC0, 8'hC0, 8'hC0, "ovf_clear");

    accept4(14'd7); waitIdle4(15);
    blank = 1'b1; settle();
    pushSlots4(8'hFF, 8'hFF, 8'hFF, 8'hF8, "v7_blank");
    blank = 1'b0; settle();
    pushSlots4(8'hC0, 8'hC0, 8'hC0, 8'hF8, "v7_noblank");
    dp4 = 4'b0100; blank = 1'b1; settle();
    pushSlots4(8'hFF, 8'h7F, 8'hFF, 8'hF8, "v7_dp_blank");
    blank = 1'b0; settle();
    pushSlots4(8'hC0, 8'h40, 8'hC0, 8'hF8, "v7_dp_noblank");
    dp4 = 4'b0000;

    // 42 offered three cycles after accepting 5 must be dropped
    accept4(14'd5);
    repeat (2) @(negedge inClk);
    bin4 = 14'd42; valid4 = 1'b1;
    @(negedge inClk);
    valid4 = 1'b0;
    waitIdle4(-1); settle();
    pushSlots4(8'hC0, 8'hC0, 8'hC0, 8'h92, "v5_ignore42");

    // six-digit instance
    bin6 = 20'd999999; valid6 = 1'b1;
    @(posedge inClk);
    @(negedge inClk);
    valid6 = 1'b0; bin6 = '0;
    doneQ6.push_back(cyc + 21);
    n = 0;
    while (!ready6 && n < 60) begin
      @(negedge inClk);
      n++;
    end
    chk("ready6_low_cycles", n, 21);
    settle();
    for (int k = 0; k < 6; k++) begin
      expEn = ~(6'd1 << k);
      pushSlot(1, {2'b0, expEn}, 8'h90, $sformatf("v999999_d%0d", k));
    end
    drain();

    n = 0;
    while (en6 != 6'b111110 && n < 40) begin
      @(negedge inClk);
      n++;
    end
    chk("en6_start", en6, 6'b111110);
    for (int i = 1; i <= 7; i++) begin
      prev = en6;
      n = 0;
      while (en6 == prev && n < 10) begin
        @(negedge inClk);
        n++;
      end
      expEn = ~(6'd1 << (i % 6));
      chk($sformatf("en6_order_%0d", i), en6, expEn);
    end

    settle();
    chk("done4_missing", doneQ4.size(), 0);
    chk("done6_missing", doneQ6.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
